// File: rtl/mor1kx_icache_refill_engine_pkg.sv
// ---------------------------------------------------------------------------
// mor1kx_icache_refill_engine_pkg
//
// Purpose: shared definitions for the instruction cache refill engine.
//   - refillStateT : one-hot engine state encoding (IDLE / BURST / ERR)
//   - nBeats()     : number of bus beats needed to fill one cache line
//   - offsetWidth(): width of the word offset inside a cache line
//
// Both helpers take the log2 line size in bytes (OPTION_ICACHE_BLOCK_WIDTH).
// Only 4 (16 byte line) and 5 (32 byte line) are meaningful for this engine.
// ---------------------------------------------------------------------------
package mor1kx_icache_refill_engine_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BURST = 3'b010,
    ERR   = 3'b100
  } refillStateT;

  // A line of 2**blockWidth bytes holds 2**(blockWidth-2) 32-bit words.
  function automatic int nBeats(input int blockWidth);
    return 1 << (blockWidth - 2);
  endfunction

  // Word offset bits inside a line, i.e. address bits [blockWidth-1:2].
  function automatic int offsetWidth(input int blockWidth);
    return blockWidth - 2;
  endfunction

endpackage

// File: rtl/mor1kx_icache_refill_engine.sv
// ---------------------------------------------------------------------------
// mor1kx_icache_refill_engine
//
// Purpose: bus-side half of the instruction cache refill port. On a cache
// miss it runs a wrapping, critical-word-first burst read on the instruction
// bus and streams every returned beat straight into the cache refill write
// port. Bus errors are reported back to the cache as its imem error input.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   refill_req_i     cache requests a refill
//   refill_i         cache is already in its REFILL state
//   ic_access_i      current fetch is cacheable
//   cpu_adr_match_i  address of the missing fetch
//   wradr_o          refill write address into the cache
//   wrdat_o          refill write data into the cache
//   we_o             refill write strobe (same cycle as the bus ack)
//   err_o            bus error during refill (same cycle as the bus error)
//   busy_o           engine is not idle
//   ibus_adr_o       bus address of the current beat
//   ibus_req_o       bus request
//   ibus_burst_o     more beats follow the current one
//   ibus_ack_i       beat accepted, read data valid
//   ibus_err_i       bus error
//   ibus_dat_i       bus read data
// ---------------------------------------------------------------------------
module mor1kx_icache_refill_engine
  import mor1kx_icache_refill_engine_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5,
  parameter int OPTION_ICACHE_LIMIT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            refill_req_i,
  input  logic                            refill_i,
  input  logic                            ic_access_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_match_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [31:0]                     wrdat_o,
  output logic                            we_o,
  output logic                            err_o,
  output logic                            busy_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_req_o,
  output logic                            ibus_burst_o,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  input  logic [31:0]                     ibus_dat_i
);

  localparam int OW     = OPTION_OPERAND_WIDTH;
  localparam int BW     = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int NBEATS = nBeats(BW);
  localparam int OFFW   = offsetWidth(BW);

  // Keeps the cacheable address bits and clears the byte offset, so the
  // latched start address is word aligned and zero above the limit width.
  localparam logic [OW-1:0] LIMIT_MASK = {OW{1'b1}} >> (OW - OPTION_ICACHE_LIMIT_WIDTH);
  localparam logic [OW-1:0] START_MASK = LIMIT_MASK & {{(OW-2){1'b1}}, 2'b00};

  refillStateT     r_state;
  refillStateT     w_nextState;
  logic [OW-1:0]   r_curAdr;
  logic [OFFW-1:0] r_beatCnt;

  logic            w_start;
  logic            w_beatDone;
  logic [OW-1:0]   w_startAdr;
  logic [OFFW-1:0] w_offInc;
  logic [OW-1:0]   w_nextAdr;

  assign w_start    = refill_req_i & ic_access_i & ~refill_i;
  assign w_startAdr = cpu_adr_match_i & START_MASK;

  // A beat only counts as written when it is acked without an error.
  assign w_beatDone = (r_state == BURST) & ibus_ack_i & ~ibus_err_i;

  // Wrap increment of the word offset: the offset field rolls over inside the
  // line while the line address above it is left untouched. This mirrors the
  // cache's own next-refill-address computation so both sides agree on order.
  assign w_offInc  = r_curAdr[BW-1:2] + OFFW'(1);
  assign w_nextAdr = {r_curAdr[OW-1:BW], w_offInc, 2'b00};

  // State, current beat address and remaining-beat counter. The counter holds
  // the number of beats still to come after the current one, so the beat
  // accepted while it reads zero is the last one of the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_curAdr  <= '0;
      r_beatCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == IDLE) && w_start) begin
        r_curAdr  <= w_startAdr;
        r_beatCnt <= OFFW'(NBEATS - 1);
      end else if (w_beatDone) begin
        r_curAdr  <= w_nextAdr;
        r_beatCnt <= r_beatCnt - OFFW'(1);
      end
    end
  end

  // Next state and all handshake outputs. The write strobe and the error flag
  // follow the bus response combinationally so the cache sees each beat in
  // the cycle it arrives; an error suppresses the write of that beat. ERR
  // lasts a single cycle to let the cache leave REFILL before a new start.
  always_comb begin
    w_nextState  = r_state;
    ibus_req_o   = 1'b0;
    ibus_burst_o = 1'b0;
    we_o         = 1'b0;
    err_o        = 1'b0;
    wrdat_o      = '0;

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_nextState = BURST;
        end
      end

      BURST: begin
        ibus_req_o   = 1'b1;
        ibus_burst_o = (r_beatCnt != '0);
        wrdat_o      = ibus_dat_i;
        if (ibus_err_i) begin
          err_o       = 1'b1;
          w_nextState = ERR;
        end else if (ibus_ack_i) begin
          we_o = 1'b1;
          if (r_beatCnt == '0) begin
            w_nextState = IDLE;
          end
        end
      end

      ERR: begin
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign busy_o     = (r_state != IDLE);
  assign ibus_adr_o = r_curAdr;
  assign wradr_o    = r_curAdr;

endmodule

// File: doc/mor1kx_icache_refill_engine.md
Name: mor1kx_icache_refill_engine

Overview:
- Bus-side counterpart of the instruction cache refill port. Services a cache miss by running a wrapping, critical-word-first burst read on the instruction bus.
- Streams each returned beat into the cache's refill write port (write address, write data, write enable).
- Sits between the icache and the ibus master in the fetch unit; reports bus errors back as the cache's imem error input.

Parameters:
- OPTION_OPERAND_WIDTH, 32, address/data width.
- OPTION_ICACHE_BLOCK_WIDTH, 5, log2 cache line bytes; only 4 (16 B, 4 beats) or 5 (32 B, 8 beats) are legal.
- OPTION_ICACHE_LIMIT_WIDTH, 32, cacheable address width; bits above are forced to zero on the bus.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- refill_req_i  in  1  cache requests refill (miss in READ, or in REFILL).
- refill_i  in  1  cache is in its REFILL state.
- ic_access_i  in  1  fetch is a cacheable access.
- cpu_adr_match_i  in  OPTION_OPERAND_WIDTH  missing fetch address.
- wradr_o  out  OPTION_OPERAND_WIDTH  refill write address to the cache.
- wrdat_o  out  32  refill write data to the cache.
- we_o  out  1  refill write strobe.
- err_o  out  1  bus error during refill (drives the cache's imem error input).
- busy_o  out  1  engine is not IDLE.
- ibus_adr_o  out  OPTION_OPERAND_WIDTH  bus address of the current beat.
- ibus_req_o  out  1  bus request.
- ibus_burst_o  out  1  more beats follow the current one.
- ibus_ack_i  in  1  beat accepted, data valid.
- ibus_err_i  in  1  bus error.
- ibus_dat_i  in  32  bus read data.

Behaviour:
- States: IDLE, BURST, ERR (one-hot, 3 bits).
- Reset (or rst at any time, including mid-burst): state=IDLE. All outputs 0 after reset; the address register is cleared to 0.
- Start condition, IDLE only: refill_req_i & ic_access_i & !refill_i.
  - Latch cur_adr = {cpu_adr_match_i[LIMIT-1:2], 2'b00}, with bits at and above LIMIT forced to 0.
  - Load beat_cnt = NBEATS-1, where NBEATS = 1<<(BLOCK_WIDTH-2).
  - Go to BURST. The first bus request appears the next cycle.
- BURST:
  - ibus_req_o=1; ibus_adr_o=cur_adr; ibus_burst_o = (beat_cnt != 0).
  - we_o = ibus_ack_i (combinational, same cycle as the ack); wradr_o=cur_adr; wrdat_o=ibus_dat_i.
- On each ack:
  - cur_adr[BLOCK_WIDTH-1:2] increments by 1, wrapping within the line.
  - Upper bits of cur_adr are unchanged.
  - beat_cnt decrements.
- Ack with beat_cnt==0 is the last beat: go to IDLE. This matches the cache's done detection (line offset of wradr+4 already valid).
- ibus_err_i in BURST:
  - err_o=1 in the same cycle (combinational); we_o=0 even if ack is also high.
  - Next state ERR.
- ERR: ibus_req_o=0; stays one cycle, then goes to IDLE. This gives the cache time to leave REFILL before a new start can be evaluated.
- In IDLE/ERR: we_o=0, ibus_req_o=0, ibus_burst_o=0, err_o=0.
- ibus_ack_i or ibus_err_i outside BURST is ignored.
- busy_o = (state != IDLE).
- Latency: miss cycle → first bus request is 1 cycle. Best case, a full line completes NBEATS cycles after the first request.
- Exactly NBEATS writes per successful refill. Each line offset is written once, starting at the critical word.

Decomposition:
- Shared package/defines: state encodings, NBEATS and line-offset width derived from the block width.
- No sub-module. The wrap-increment is an inline expression of the same form as the cache's next-refill-address computation.

Test Plan:
1. BLOCK_WIDTH=5, miss at 0x0000_1014, ack every cycle → ibus_adr_o sequence 0x14, 0x18, 0x1C, 0x00, 0x04, 0x08, 0x0C, 0x10 (upper 0x0000_1000). Eight we_o pulses with wradr_o equal to ibus_adr_o; ibus_burst_o low only on 0x1010; then IDLE.
2. BLOCK_WIDTH=4, miss at 0x2000_000C, acks with 2 wait cycles each → addresses 0xC, 0x0, 0x4, 0x8. we_o only on ack cycles; wrdat_o equals ibus_dat_i; wradr/wrdat held stable across waits.
3. Error on the 3rd beat → err_o=1 exactly one cycle with we_o=0. ERR for 1 cycle, then IDLE. A new miss afterwards restarts from the new critical word.
4. rst asserted mid-burst after 2 beats → next cycle IDLE, ibus_req_o=0, we_o=0. A subsequent miss performs a full 8-beat refill.
5. refill_req_i=1 with refill_i=1 while in IDLE, or refill_req_i=1 with ic_access_i=0 → no start, ibus_req_o stays 0.
6. Back-to-back misses (a new miss one cycle after the last beat) → second burst's first request 1 cycle after the miss cycle; no beats lost or duplicated.
